// File: rtl/vga_timing_gen.sv
// VGA raster timing generator on a single clock, advancing on a divided pixel-enable strobe.
// Optional window comparators and linear window address are built when VGA_TIMING_WIN_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned CLK_DIV  = 2,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned WIN_X0   = 0,
  parameter int unsigned WIN_Y0   = 0,
  parameter int unsigned WIN_W    = 250,
  parameter int unsigned WIN_H    = 250,
  parameter int unsigned ADDR_W   = 16
) (
  input  logic              clk50,
  input  logic              rst,
  output logic              pix_en,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic [10:0]       counter_x,
  output logic [10:0]       counter_y,
  output logic              line_start,
  output logic              frame_start,
  output logic              win_active,
  output logic [ADDR_W-1:0] win_addr
);

  localparam int unsigned CW       = 11;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC;
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Reject configurations the counters and address cannot represent
  if (CLK_DIV == 0 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be in 1..16");
  end
  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_total
    $error("vga_timing_gen: raster totals exceed 11-bit counters");
  end
  if ((64'(WIN_W) * 64'(WIN_H)) > (64'd1 << ADDR_W)) begin : g_bad_addr
    $error("vga_timing_gen: ADDR_W too small for WIN_W*WIN_H");
  end
  if ((WIN_X0 + WIN_W) > 2048 || (WIN_Y0 + WIN_H) > 2048) begin : g_bad_win
    $error("vga_timing_gen: window exceeds coordinate range");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en_q, pix_en_d;
  logic [CW-1:0]    x_q, x_d, y_q, y_d;
  logic             x_last_c, y_last_c;
  logic             hs_on_c, vs_on_c, de_c, ls_c, fs_c;

  logic             hsync_q, hsync_d, vsync_q, vsync_d;
  logic             de_q, de_d, ls_q, ls_d, fs_q, fs_d;
  logic [CW-1:0]    cx_q, cx_d, cy_q, cy_d;

  // Pixel-enable divider
  always_comb begin : div_next
    div_d    = div_q + DIV_W'(1);
    pix_en_d = 1'b0;
    if (div_q == DIV_W'(CLK_DIV - 1)) begin
      div_d    = '0;
      pix_en_d = 1'b1;
    end
  end

  assign x_last_c = (x_q == CW'(H_TOTAL - 1));
  assign y_last_c = (y_q == CW'(V_TOTAL - 1));

  // Raster position
  always_comb begin : pos_next
    x_d = x_q;
    y_d = y_q;
    if (pix_en_q) begin
      if (x_last_c) begin
        x_d = '0;
        y_d = y_last_c ? '0 : (y_q + CW'(1));
      end else begin
        x_d = x_q + CW'(1);
      end
    end
  end

  // Decode of the current position
  assign hs_on_c = (x_q >= CW'(HS_START)) && (x_q < CW'(HS_END));
  assign vs_on_c = (y_q >= CW'(VS_START)) && (y_q < CW'(VS_END));
  assign de_c    = (x_q < CW'(H_ACTIVE)) && (y_q < CW'(V_ACTIVE));
  assign ls_c    = (x_q == '0);
  assign fs_c    = ls_c && (y_q == '0);

  // Outputs capture the decoded position once per pixel and hold for the period
  always_comb begin : out_next
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    de_d    = de_q;
    ls_d    = ls_q;
    fs_d    = fs_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    if (pix_en_q) begin
      hsync_d = hs_on_c ? HS_POL : ~HS_POL;
      vsync_d = vs_on_c ? VS_POL : ~VS_POL;
      de_d    = de_c;
      ls_d    = ls_c;
      fs_d    = fs_c;
      cx_d    = x_q;
      cy_d    = y_q;
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      hsync_q  <= ~HS_POL;
      vsync_q  <= ~VS_POL;
      de_q     <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      cx_q     <= '0;
      cy_q     <= '0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      x_q      <= x_d;
      y_q      <= y_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      ls_q     <= ls_d;
      fs_q     <= fs_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign counter_x   = cx_q;
  assign counter_y   = cy_q;

`ifdef VGA_TIMING_WIN_EN
  localparam int unsigned       WW       = CW + 1;
  localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN_W * WIN_H - 1);

  logic [WW-1:0]     wx_off_c, wy_off_c;
  logic              win_c;
  logic [ADDR_W-1:0] waddr_q, waddr_d, win_addr_q, win_addr_d;
  logic              win_active_q, win_active_d;

  // Offsets below the origin wrap high, so one compare covers both bounds
  assign wx_off_c = {1'b0, x_q} - WW'(WIN_X0);
  assign wy_off_c = {1'b0, y_q} - WW'(WIN_Y0);
  assign win_c    = de_c && (wx_off_c < WW'(WIN_W)) && (wy_off_c < WW'(WIN_H));

  // waddr_q always holds the address of the next window pixel; it saturates at the last one
  always_comb begin : win_next
    waddr_d      = waddr_q;
    win_addr_d   = win_addr_q;
    win_active_d = win_active_q;
    if (pix_en_q) begin
      win_active_d = win_c;
      win_addr_d   = waddr_q;
      if (x_last_c && y_last_c) begin
        waddr_d = '0;
      end else if (win_c && (waddr_q != WIN_LAST)) begin
        waddr_d = waddr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      waddr_q      <= '0;
      win_addr_q   <= '0;
      win_active_q <= 1'b0;
    end else begin
      waddr_q      <= waddr_d;
      win_addr_q   <= win_addr_d;
      win_active_q <= win_active_d;
    end
  end

  assign win_active = win_active_q;
  assign win_addr   = win_addr_q;
`else
  assign win_active = 1'b0;
  assign win_addr   = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised-reset bench for vga_timing_gen: two small configurations checked every cycle
// against an arithmetic model derived from cycles elapsed since reset.
module tb_vga_timing_gen;

  typedef struct packed {
    int ha; int hf; int hsw; int hb;
    int va; int vf; int vsw; int vb;
    int div; int hpol; int vpol;
    int wx; int wy; int ww; int wh;
  } cfg_t;

  localparam cfg_t CFG_A = '{ha:20, hf:3, hsw:5, hb:4, va:12, vf:2, vsw:3, vb:2,
                             div:3, hpol:0, vpol:1, wx:4, wy:3, ww:10, wh:6};
  localparam cfg_t CFG_B = '{ha:8, hf:2, hsw:3, hb:1, va:6, vf:1, vsw:2, vb:1,
                             div:1, hpol:1, vpol:0, wx:0, wy:0, ww:5, wh:4};
  localparam int unsigned AW_A = 6;
  localparam int unsigned AW_B = 5;
  localparam int CLEAN_CYC = 2 * 608 * 3 + 100;
  localparam int RAND_CYC  = 4000;

  logic clk50 = 1'b0;
  logic rst   = 1'b1;
  always #5 clk50 = ~clk50;

  logic            a_pe, a_hs, a_vs, a_de, a_ls, a_fs, a_wa;
  logic [10:0]     a_cx, a_cy;
  logic [AW_A-1:0] a_waddr;
  logic            b_pe, b_hs, b_vs, b_de, b_ls, b_fs, b_wa;
  logic [10:0]     b_cx, b_cy;
  logic [AW_B-1:0] b_waddr;

  vga_timing_gen #(
    .H_ACTIVE(CFG_A.ha), .H_FP(CFG_A.hf), .H_SYNC(CFG_A.hsw), .H_BP(CFG_A.hb),
    .V_ACTIVE(CFG_A.va), .V_FP(CFG_A.vf), .V_SYNC(CFG_A.vsw), .V_BP(CFG_A.vb),
    .CLK_DIV(CFG_A.div), .HS_POL(1'(CFG_A.hpol)), .VS_POL(1'(CFG_A.vpol)),
    .WIN_X0(CFG_A.wx), .WIN_Y0(CFG_A.wy), .WIN_W(CFG_A.ww), .WIN_H(CFG_A.wh), .ADDR_W(AW_A)
  ) u_dut_a (
    .clk50(clk50), .rst(rst), .pix_en(a_pe), .hsync(a_hs), .vsync(a_vs), .de(a_de),
    .counter_x(a_cx), .counter_y(a_cy), .line_start(a_ls), .frame_start(a_fs),
    .win_active(a_wa), .win_addr(a_waddr)
  );

  vga_timing_gen #(
    .H_ACTIVE(CFG_B.ha), .H_FP(CFG_B.hf), .H_SYNC(CFG_B.hsw), .H_BP(CFG_B.hb),
    .V_ACTIVE(CFG_B.va), .V_FP(CFG_B.vf), .V_SYNC(CFG_B.vsw), .V_BP(CFG_B.vb),
    .CLK_DIV(CFG_B.div), .HS_POL(1'(CFG_B.hpol)), .VS_POL(1'(CFG_B.vpol)),
    .WIN_X0(CFG_B.wx), .WIN_Y0(CFG_B.wy), .WIN_W(CFG_B.ww), .WIN_H(CFG_B.wh), .ADDR_W(AW_B)
  ) u_dut_b (
    .clk50(clk50), .rst(rst), .pix_en(b_pe), .hsync(b_hs), .vsync(b_vs), .de(b_de),
    .counter_x(b_cx), .counter_y(b_cy), .line_start(b_ls), .frame_start(b_fs),
    .win_active(b_wa), .win_addr(b_waddr)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t (cycle %0d)", tag, obs, exp, $time, cyc);
    end
  endtask

  // Count of window pixels already emitted this frame before (x,y), capped at the last address
  function automatic int win_next(input cfg_t g, input int x, input int y);
    int rows, col, n;
    if (y < g.wy) return 0;
    rows = y - g.wy;
    if (rows > g.wh) rows = g.wh;
    col = 0;
    if (y < g.wy + g.wh) begin
      col = x - g.wx;
      if (col < 0) col = 0;
      if (col > g.ww) col = g.ww;
    end
    n = rows * g.ww + col;
    if (n > g.ww * g.wh - 1) n = g.ww * g.wh - 1;
    return n;
  endfunction

  task automatic check_inst(input string pfx, input cfg_t g,
                            input logic pe, input logic hs, input logic vs, input logic de,
                            input logic [10:0] cx, input logic [10:0] cy,
                            input logic ls, input logic fs, input logic wa,
                            input logic [31:0] waddr);
    int ht, vt, u, p, x, y;
    int e_hs, e_vs, e_de, e_ls, e_fs, e_wa, e_addr;
    ht = g.ha + g.hf + g.hsw + g.hb;
    vt = g.va + g.vf + g.vsw + g.vb;
    u  = (cyc >= g.div + 1) ? (cyc - 1) / g.div : 0;
    chk({pfx, ".pix_en"}, 32'(pe), (cyc > 0 && (cyc % g.div) == 0) ? 32'd1 : 32'd0);
    if (u == 0) begin
      x = 0; y = 0;
      e_hs = 1 - g.hpol; e_vs = 1 - g.vpol;
      e_de = 0; e_ls = 0; e_fs = 0; e_wa = 0; e_addr = 0;
    end else begin
      p = u - 1;
      x = p % ht;
      y = (p / ht) % vt;
      e_hs = (x >= g.ha + g.hf && x < g.ha + g.hf + g.hsw) ? g.hpol : 1 - g.hpol;
      e_vs = (y >= g.va + g.vf && y < g.va + g.vf + g.vsw) ? g.vpol : 1 - g.vpol;
      e_de = (x < g.ha && y < g.va) ? 1 : 0;
      e_ls = (x == 0) ? 1 : 0;
      e_fs = (x == 0 && y == 0) ? 1 : 0;
      e_wa = (e_de == 1 && x >= g.wx && x < g.wx + g.ww && y >= g.wy && y < g.wy + g.wh) ? 1 : 0;
      e_addr = win_next(g, x, y);
    end
`ifndef VGA_TIMING_WIN_EN
    e_wa = 0;
    e_addr = 0;
`endif
    chk({pfx, ".counter_x"}, 32'(cx), x);
    chk({pfx, ".counter_y"}, 32'(cy), y);
    chk({pfx, ".hsync"}, 32'(hs), e_hs);
    chk({pfx, ".vsync"}, 32'(vs), e_vs);
    chk({pfx, ".de"}, 32'(de), e_de);
    chk({pfx, ".line_start"}, 32'(ls), e_ls);
    chk({pfx, ".frame_start"}, 32'(fs), e_fs);
    chk({pfx, ".win_active"}, 32'(wa), e_wa);
    chk({pfx, ".win_addr"}, waddr, e_addr);
  endtask

  task automatic step(input logic r);
    rst = r;
    @(posedge clk50);
    if (r) cyc = 0;
    else if (cyc >= 0) cyc++;
    @(negedge clk50);
    if (cyc >= 0) begin
      check_inst("A", CFG_A, a_pe, a_hs, a_vs, a_de, a_cx, a_cy, a_ls, a_fs, a_wa, 32'(a_waddr));
      check_inst("B", CFG_B, b_pe, b_hs, b_vs, b_de, b_cx, b_cy, b_ls, b_fs, b_wa, 32'(b_waddr));
    end
  endtask

  initial begin
    int forced_at;
    repeat (3) step(1'b1);
    repeat (CLEAN_CYC) step(1'b0);
    forced_at = int'($urandom_range(500, 1500));
    for (int i = 0; i < RAND_CYC; i++) begin
      if (i == forced_at || $urandom_range(0, 999) == 0) begin
        repeat (int'($urandom_range(1, 4))) step(1'b1);
      end else begin
        step(1'b0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
